// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB control FSM sharing one
// instruction/data memory port behind a req/ready handshake.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          NUM_REGS    = 32,
   parameter int          MEM_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        instr_done,
   output logic        halted,
   output logic [31:0] pc_out
);

   localparam int         RW   = $clog2(NUM_REGS);
   localparam logic [5:0] NREG = 6'(NUM_REGS);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   logic [2:0]  state;
   logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr, wait_cnt;
   logic [31:0] regs [NUM_REGS];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wb_dst;
   logic [31:0] sext_imm, alu_r, addr_sum, exec_pc, wb_data;
   logic        is_rtype, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_flow;
   logic        funct_ok, regs_ok, legal, taken, wait_expired, unused_bits;

   assign opcode      = ir[31:26];
   assign rs          = ir[25:21];
   assign rt          = ir[20:16];
   assign rd          = ir[15:11];
   assign funct       = ir[5:0];
   assign sext_imm    = {{16{ir[15]}}, ir[15:0]};
   assign unused_bits = ^ir[10:6];

   assign is_rtype = (opcode == OP_RTYPE);
   assign is_lw    = (opcode == OP_LW);
   assign is_sw    = (opcode == OP_SW);
   assign is_beq   = (opcode == OP_BEQ);
   assign is_bne   = (opcode == OP_BNE);
   assign is_addi  = (opcode == OP_ADDI);
   assign is_j     = (opcode == OP_J);
   assign is_flow  = is_beq | is_bne | is_j;

   always_comb begin
      funct_ok = 1'b0;
      alu_r    = a_reg + b_reg;
      case (funct)
         F_ADD: begin funct_ok = 1'b1; alu_r = a_reg + b_reg; end
         F_SUB: begin funct_ok = 1'b1; alu_r = a_reg - b_reg; end
         F_AND: begin funct_ok = 1'b1; alu_r = a_reg & b_reg; end
         F_OR:  begin funct_ok = 1'b1; alu_r = a_reg | b_reg; end
         F_SLT: begin funct_ok = 1'b1; alu_r = {31'd0, $signed(a_reg) < $signed(b_reg)}; end
         default: ;
      endcase
   end

   // Register fields are only meaningful for R/I formats; j carries a target there.
   assign regs_ok = ({1'b0, rs} < NREG) && ({1'b0, rt} < NREG) && (!is_rtype || ({1'b0, rd} < NREG));
   assign legal   = ((is_rtype && funct_ok) || is_lw || is_sw || is_beq || is_bne || is_addi || is_j)
                    && (is_j || regs_ok);

   assign addr_sum = a_reg + sext_imm;
   assign taken    = is_beq ? (a_reg == b_reg) : (a_reg != b_reg);
   assign exec_pc  = is_j ? {pc[31:28], ir[25:0], 2'b00} : (taken ? pc + {sext_imm[29:0], 2'b00} : pc);
   assign wb_dst   = is_rtype ? rd : rt;
   assign wb_data  = is_lw ? mdr : alu_out;

   assign wait_expired = (MEM_TIMEOUT > 0) && mem_req && !mem_ready && (wait_cnt == 32'(MEM_TIMEOUT - 1));

   assign instr_done = ((state == S_EXEC) && is_flow) || (state == S_WB)
                       || ((state == S_MEM) && is_sw && mem_req && mem_ready);
   assign pc_out     = pc;

   // Memory outputs are registered so they stay stable for the whole request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         ir        <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         alu_out   <= '0;
         mdr       <= '0;
         wait_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         halted    <= 1'b0;
      end else begin
         wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 32'd1 : '0;
         case (state)
            S_FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  pc      <= pc + 32'd4;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end else if (wait_expired) begin
                  mem_req <= 1'b0;
                  halted  <= 1'b1;
                  state   <= S_HALT;
               end
            end
            S_DECODE: begin
               if (!legal) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  a_reg <= (rs == 5'd0) ? '0 : regs[rs[RW-1:0]];
                  b_reg <= (rt == 5'd0) ? '0 : regs[rt[RW-1:0]];
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_flow) begin
                  pc       <= exec_pc;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= exec_pc;
                  state    <= S_FETCH;
               end else if (is_rtype) begin
                  alu_out <= alu_r;
                  state   <= S_WB;
               end else if (is_addi) begin
                  alu_out <= addr_sum;
                  state   <= S_WB;
               end else begin
                  alu_out <= addr_sum;
                  if (addr_sum[1:0] != 2'b00) begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= is_sw;
                     mem_addr  <= addr_sum;
                     mem_wdata <= is_sw ? b_reg : '0;
                     state     <= S_MEM;
                  end
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (is_sw) begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= pc;
                     state    <= S_FETCH;
                  end else begin
                     mdr     <= mem_rdata;
                     mem_req <= 1'b0;
                     state   <= S_WB;
                  end
               end else if (wait_expired) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  halted  <= 1'b1;
                  state   <= S_HALT;
               end
            end
            S_WB: begin
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= pc;
               state    <= S_FETCH;
            end
            S_HALT: ;
            default: begin
               mem_req <= 1'b0;
               halted  <= 1'b1;
               state   <= S_HALT;
            end
         endcase
      end
   end

   // Register file; index 0 is never written so it always reads as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (state == S_WB && wb_dst != 5'd0) begin
         regs[wb_dst[RW-1:0]] <= wb_data;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed testbench for mips_multicycle_core: a main core with a wait-state memory
// model, plus small instances for RESET_PC/timeout and NUM_REGS=16 fault cases.
module tb_mips_multicycle_core;

   logic        clk;
   logic        rst_n, mem_req, mem_we, mem_ready, instr_done, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

   logic        rst_b, req_b, we_b, ready_b, done_b, halted_b;
   logic [31:0] addr_b, wdata_b, rdata_b, pc_b;

   logic        rst_c, req_c, we_c, ready_c, done_c, halted_c;
   logic [31:0] addr_c, wdata_c, rdata_c, pc_c;

   int checks, errors;

   logic [31:0] mem [0:255];
   int          wait_states, wcnt, cyc, stable_err;
   int          retire_q[$], req_cyc[$];
   logic [31:0] req_addr_q[$], wr_addr_q[$], wr_data_q[$];
   logic [31:0] cap_addr, cap_wdata;
   logic        cap_we;

   mips_multicycle_core dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .instr_done(instr_done), .halted(halted), .pc_out(pc_out));

   mips_multicycle_core #(.RESET_PC(32'h100), .MEM_TIMEOUT(4)) dut_b (
      .clk(clk), .rst_n(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
      .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ready(ready_b),
      .instr_done(done_b), .halted(halted_b), .pc_out(pc_b));

   mips_multicycle_core #(.NUM_REGS(16)) dut_c (
      .clk(clk), .rst_n(rst_c), .mem_req(req_c), .mem_we(we_c), .mem_addr(addr_c),
      .mem_wdata(wdata_c), .mem_rdata(rdata_c), .mem_ready(ready_c),
      .instr_done(done_c), .halted(halted_c), .pc_out(pc_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input int target);
      return {6'b000010, 26'(target)};
   endfunction

   // Memory model: fetches (addr == pc_out) are zero-wait, data accesses get wait_states.
   initial begin
      wcnt = 0; cyc = 0; stable_err = 0; mem_ready = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mem_req) begin
            if (wcnt == 0) begin
               cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
               req_addr_q.push_back(mem_addr);
               req_cyc.push_back(cyc);
            end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
               stable_err++;
            end
            if (mem_addr != pc_out && wcnt < wait_states) begin
               mem_ready = 1'b0;
               wcnt++;
            end else begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr[9:2]];
               if (mem_we) begin
                  mem[mem_addr[9:2]] = mem_wdata;
                  wr_addr_q.push_back(mem_addr);
                  wr_data_q.push_back(mem_wdata);
               end
               wcnt = 0;
            end
         end else begin
            mem_ready = 1'b0;
            wcnt = 0;
         end
         #1;
         if (instr_done) retire_q.push_back(cyc);
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic begin_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wait_states = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      for (int i = 32; i < 40; i++) mem[i] = 32'hDEAD_BEEF;
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      retire_q.delete(); req_cyc.delete(); req_addr_q.delete();
      wr_addr_q.delete(); wr_data_q.delete();
      stable_err = 0;
      rst_n = 1'b1;
   endtask

   task automatic wait_retire(input int n);
      int budget = 300;
      while (retire_q.size() < n && !halted && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      #2;
      checks++;
      if (retire_q.size() < n) begin
         errors++;
         $display("[TB] FAIL retire_count got %0d expected %0d", retire_q.size(), n);
      end
   endtask

   task automatic wait_halt(input string name);
      int budget = 100;
      while (!halted && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_halted got %b expected 1", name, halted);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
          || instr_done !== 1'b0 || halted !== 1'b0 || pc_out !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got req=%b we=%b addr=%h wd=%h done=%b halt=%b pc=%h expected all zero",
                  mem_req, mem_we, mem_addr, mem_wdata, instr_done, halted, pc_out);
      end
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      checks++;
      if (req_b !== 1'b1 || addr_b !== 32'h100 || we_b !== 1'b0 || pc_b !== 32'h100) begin
         errors++;
         $display("[TB] FAIL first_fetch got req=%b addr=%h we=%b pc=%h expected req=1 addr=00000100 we=0 pc=00000100",
                  req_b, addr_b, we_b, pc_b);
      end
      rst_b = 1'b0;
      #1;
      checks++;
      if (req_b !== 1'b0 || addr_b !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_drops_req got req=%b addr=%h expected req=0 addr=00000000", req_b, addr_b);
      end
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   task automatic test_timeout();
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (halted_b) break;
         if (req_b) n++;
      end
      checks++;
      if (halted_b !== 1'b1 || n != 4) begin
         errors++;
         $display("[TB] FAIL timeout got halted=%b req_cycles=%0d expected halted=1 req_cycles=4", halted_b, n);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (req_b !== 1'b0 || pc_b !== 32'h100) begin
         errors++;
         $display("[TB] FAIL timeout_hold got req=%b pc=%h expected req=0 pc=00000100", req_b, pc_b);
      end
   endtask

   task automatic test_arith();
      logic [31:0] exp_val [6] = '{32'd2, 32'd1, 32'hFFFF_FFF8, 32'd5, 32'hFFFF_FFFD, 32'd0};
      begin_reset();
      mem[0] = enc_i(6'b001000, 0, 1, 5);
      mem[1] = enc_i(6'b001000, 0, 2, -3);
      mem[2] = enc_r(1, 2, 3, 6'b100000);
      mem[3] = enc_r(2, 1, 4, 6'b101010);
      mem[4] = enc_r(2, 1, 5, 6'b100010);
      mem[5] = enc_r(1, 2, 6, 6'b100100);
      mem[6] = enc_r(1, 2, 7, 6'b100101);
      mem[7] = enc_r(1, 2, 8, 6'b101010);
      for (int i = 0; i < 6; i++) mem[8 + i] = enc_i(6'b101011, 0, 3 + i, 32'h80 + 4 * i);
      release_reset();
      wait_retire(14);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (mem[32 + i] !== exp_val[i]) begin
            errors++;
            $display("[TB] FAIL arith_reg%0d got %h expected %h", 3 + i, mem[32 + i], exp_val[i]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (retire_q.size() > k + 1 && retire_q[k + 1] - retire_q[k] != 4) begin
            errors++;
            $display("[TB] FAIL arith_latency%0d got %0d expected 4", k + 1, retire_q[k + 1] - retire_q[k]);
         end
      end
      checks++;
      if (retire_q.size() > 9 && retire_q[9] - retire_q[8] != 4) begin
         errors++;
         $display("[TB] FAIL sw_latency got %0d expected 4", retire_q[9] - retire_q[8]);
      end
   endtask

   task automatic test_load_store();
      begin_reset();
      mem[0]  = enc_i(6'b001000, 0, 3, 2);
      mem[1]  = enc_j(32'h10);
      mem[16] = enc_i(6'b101011, 0, 3, 8);
      mem[17] = enc_i(6'b100011, 0, 6, 8);
      mem[18] = enc_i(6'b101011, 0, 6, 32'h80);
      release_reset();
      wait_states = 2;
      wait_retire(5);
      checks++;
      if (wr_addr_q.size() < 1 || wr_addr_q[0] !== 32'h8 || wr_data_q[0] !== 32'h2) begin
         errors++;
         $display("[TB] FAIL sw_write got addr=%h data=%h expected addr=00000008 data=00000002",
                  wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx, wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx);
      end
      checks++;
      if (stable_err != 0) begin
         errors++;
         $display("[TB] FAIL req_stable got %0d changes expected 0", stable_err);
      end
      checks++;
      if (mem[32] !== 32'h2) begin
         errors++;
         $display("[TB] FAIL lw_result got %h expected 00000002", mem[32]);
      end
      checks++;
      if (retire_q.size() > 3 && (retire_q[2] - retire_q[1] != 6 || retire_q[3] - retire_q[2] != 7)) begin
         errors++;
         $display("[TB] FAIL wait_latency got sw=%0d lw=%0d expected sw=6 lw=7",
                  retire_q[2] - retire_q[1], retire_q[3] - retire_q[2]);
      end
      wait_states = 0;
   endtask

   task automatic test_control();
      logic [31:0] exp_req [8] = '{32'h0, 32'hC, 32'h10, 32'h100, 32'h104, 32'h80, 32'h108, 32'h84};
      begin_reset();
      mem[0]  = enc_i(6'b000100, 0, 0, 2);
      mem[1]  = enc_i(6'b001000, 0, 7, 1);
      mem[2]  = enc_i(6'b001000, 0, 7, 2);
      mem[3]  = enc_i(6'b001000, 0, 1, 5);
      mem[4]  = enc_j(32'h40);
      mem[64] = enc_i(6'b000101, 1, 1, 4);
      mem[65] = enc_i(6'b101011, 0, 1, 32'h80);
      mem[66] = enc_i(6'b101011, 0, 7, 32'h84);
      release_reset();
      wait_retire(6);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (req_addr_q.size() <= i || req_addr_q[i] !== exp_req[i]) begin
            errors++;
            $display("[TB] FAIL flow_req%0d got %h expected %h", i,
                     req_addr_q.size() > i ? req_addr_q[i] : 32'hx, exp_req[i]);
         end
      end
      checks++;
      if (retire_q.size() > 3 && (retire_q[0] - req_cyc[0] + 1 != 3 || retire_q[2] - retire_q[1] != 3
          || retire_q[3] - retire_q[2] != 3)) begin
         errors++;
         $display("[TB] FAIL flow_latency got beq=%0d j=%0d bne=%0d expected 3 each",
                  retire_q[0] - req_cyc[0] + 1, retire_q[2] - retire_q[1], retire_q[3] - retire_q[2]);
      end
      checks++;
      if (mem[32] !== 32'd5 || mem[33] !== 32'd0) begin
         errors++;
         $display("[TB] FAIL flow_regs got r1=%h r7=%h expected r1=00000005 r7=00000000", mem[32], mem[33]);
      end
   endtask

   task automatic test_faults();
      int n;
      begin_reset();
      mem[0] = enc_i(6'b001000, 0, 1, 7);
      mem[1] = 32'hFC00_0000;
      mem[2] = enc_i(6'b101011, 0, 1, 32'h80);
      release_reset();
      wait_halt("illegal_op");
      n = 0;
      repeat (5) begin @(negedge clk); if (mem_req) n++; end
      checks++;
      if (n != 0 || pc_out !== 32'h8 || mem[32] !== 32'hDEAD_BEEF || req_addr_q[$] !== 32'h4) begin
         errors++;
         $display("[TB] FAIL illegal_op_state got reqs=%0d pc=%h m80=%h last_req=%h expected 0 00000008 deadbeef 00000004",
                  n, pc_out, mem[32], req_addr_q[$]);
      end

      begin_reset();
      mem[0] = enc_i(6'b001000, 0, 1, 7);
      mem[1] = enc_i(6'b101011, 0, 1, 32'h80);
      mem[2] = enc_i(6'b100011, 0, 2, 6);
      mem[3] = enc_i(6'b101011, 0, 1, 32'h84);
      release_reset();
      wait_halt("misaligned");
      n = 0;
      repeat (5) begin @(negedge clk); if (mem_req) n++; end
      checks++;
      if (n != 0 || pc_out !== 32'hC || mem[32] !== 32'd7 || mem[33] !== 32'hDEAD_BEEF || req_addr_q[$] !== 32'h8) begin
         errors++;
         $display("[TB] FAIL misaligned_state got reqs=%0d pc=%h m80=%h m84=%h last_req=%h expected 0 0000000c 00000007 deadbeef 00000008",
                  n, pc_out, mem[32], mem[33], req_addr_q[$]);
      end

      rst_c = 1'b1;
      n = 0;
      for (int i = 0; i < 20 && !halted_c; i++) @(negedge clk);
      repeat (5) begin @(negedge clk); if (req_c) n++; end
      checks++;
      if (halted_c !== 1'b1 || n != 0 || pc_c !== 32'h4) begin
         errors++;
         $display("[TB] FAIL regidx_halt got halted=%b reqs=%0d pc=%h expected halted=1 reqs=0 pc=00000004",
                  halted_c, n, pc_c);
      end
   endtask

   task automatic test_reg_zero();
      begin_reset();
      mem[0] = enc_i(6'b001000, 0, 1, 9);
      mem[1] = enc_r(1, 1, 0, 6'b100000);
      mem[2] = enc_i(6'b101011, 0, 0, 32'h80);
      mem[3] = enc_i(6'b101011, 0, 1, 32'h84);
      release_reset();
      wait_retire(4);
      checks++;
      if (mem[32] !== 32'd0 || mem[33] !== 32'd9) begin
         errors++;
         $display("[TB] FAIL reg_zero got r0=%h r1=%h expected r0=00000000 r1=00000009", mem[32], mem[33]);
      end
   endtask

   initial begin
      checks = 0; errors = 0; wait_states = 0;
      rst_n = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      ready_b = 1'b0; rdata_b = '0;
      ready_c = 1'b1; rdata_c = enc_r(1, 1, 20, 6'b100000);
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_timeout();
      test_arith();
      test_load_store();
      test_control();
      test_faults();
      test_reg_zero();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multi-cycle MIPS-subset core: one instruction executes over 3–5 states of an internal control FSM.
- Successor to the single-cycle datapath. Control unit, ALU decode and register file are internal.
- One shared instruction/data memory sits behind a req/ready handshake, so wait states are supported.
- Adds reset, bne, misalignment/illegal-opcode halting, a configurable register count and a retire pulse.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NUM_REGS, 32: architectural registers, 16 or 32. Any rs/rt/rd index >= NUM_REGS is illegal.
- MEM_TIMEOUT, 0: maximum cycles to wait for mem_ready. 0 disables the timeout; otherwise expiry halts the core.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = store, 0 = load/fetch.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data (rt).
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  completes the current request.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  sticky halt flag.
- pc_out  out  32  current PC.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, all registers 0, state=FETCH.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_done=0, halted=0.
  - Reset mid-access drops mem_req immediately; the aborted request has no architectural effect.
- Handshake:
  - While mem_req=1, mem_addr, mem_we and mem_wdata stay stable.
  - A transfer completes on the first edge where mem_req & mem_ready. mem_req deasserts the next cycle unless a new request follows.
  - mem_ready is ignored while mem_req=0.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drive req with addr=pc, we=0.
  - On ready: IR <- mem_rdata, pc <- pc+4, go to DECODE.
- DECODE:
  - A <- reg[rs], B <- reg[rt] (reg 0 reads 0).
  - Check opcode, funct and register indices. Illegal → HALT.
- EXEC:
  - R-type: ALUout <- A op B; go to WB.
  - addi, lw, sw: ALUout <- A + sext(imm16).
    - addi goes to WB.
    - lw/sw with ALUout[1:0] != 0 → HALT; no memory access is issued.
    - Aligned lw/sw go to MEM.
  - beq/bne: if taken, pc <- pc + (sext(imm16)<<2), where pc is already pc+4. Retire, go to FETCH.
  - j: pc <- {pc[31:28], imm26, 2'b00}. Retire, go to FETCH.
- MEM:
  - lw: req, we=0, addr=ALUout. On ready: MDR <- rdata, go to WB.
  - sw: req, we=1, addr=ALUout, wdata=B. On ready: retire, go to FETCH.
- WB:
  - Destination is rd (R-type) or rt (addi, lw).
  - Writes to reg 0 are discarded. Retire, go to FETCH.
- Supported instructions:
  - R-type (op 000000) funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - Other opcodes: lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
  - Anything else is illegal.
- Arithmetic:
  - 32-bit wraparound; no overflow trap.
  - slt is a signed compare, result 32'd1 or 32'd0.
- Latency in cycles with zero wait states (mem_ready=1 in the first req cycle):
  - beq/bne/j: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
  - Each wait cycle adds 1.
- instr_done is high for exactly 1 cycle, in the retiring state.
- HALT:
  - halted=1, mem_req=0, no further state change.
  - Left only by reset. pc_out holds the pc after the faulting fetch.
- MEM_TIMEOUT>0: a wait counter resets on each new request. Reaching MEM_TIMEOUT without ready → HALT.

Test Plan:
1. Reset and fetch: rst_n low mid-fetch with RESET_PC=0x100 → mem_req=0 at once. After release, first req has addr=0x100, we=0.
2. Arithmetic, zero wait:
   - Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sub $5,$2,$1.
   - Expect $3=2, $4=1, $5=0xFFFFFFF8, with instr_done every 4 cycles.
3. Load/store with waits:
   - sw $3,8($0) then lw $6,8($0), memory inserting 2 wait cycles.
   - Expect write addr=8 data=2 with inputs stable across the waits; $6=2; lw takes 7 cycles.
4. Control flow:
   - beq $0,$0,+2 at 0x0 → next fetch 0xC.
   - bne $1,$1 → next fetch pc+4.
   - j 0x40 at 0x10 → next fetch 0x100.
   - Each takes 3 cycles.
5. Faults:
   - Opcode 111111, lw at address 0x6, and NUM_REGS=16 with rd=20 each → halted=1.
   - No mem_req after the fault; register file unchanged.
6. Timeout and reg 0:
   - MEM_TIMEOUT=4 with mem_ready held low → halted after 4 req cycles.
   - Separately, add $0,$1,$1 → $0 still reads 0.
